// File: rtl/regfile_reader_if.sv
// regfile_reader_if: command, register-file read port and output stream of regfile_reader
interface regfile_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rf_we;
  logic              rf_lock;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  modport master (
    input  start, base, count, rdata, rf_we, out_ready,
    output raddr, rf_lock, out_valid, out_data, out_addr, out_last, busy, done
  );
  modport slave (
    output start, base, count, rdata, rf_we, out_ready,
    input  raddr, rf_lock, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/regfile_reader.sv
// regfile_reader: walks a block of register addresses and streams the words out with addr/last tags
module regfile_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic             clk,
  input  logic             rst,
  regfile_reader_if.master m
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam logic [ADDR_W:0] NREG_C = (ADDR_W+1)'(NREG);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W:0]   r_rem;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_lock;
  logic              r_done;
  logic              w_fire;
  logic              w_cap;
  assign w_fire = r_out_valid & m.out_ready;
  // rdata reads as zero during a write, so never capture then; also wait for a free output register
  assign w_cap  = (r_state == READ) & ~m.rf_we & (~r_out_valid | m.out_ready);
  // read-out FSM: command decode, capture/advance in READ, last-word handoff in DRAIN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_raddr     <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_lock      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m.start && m.count == '0) begin
            r_done <= 1'b1;
          end else if (m.start) begin
            r_raddr <= m.base;
            r_rem   <= (m.count > NREG_C) ? NREG_C : m.count;
            r_busy  <= 1'b1;
            r_lock  <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          if (w_cap) begin
            r_out_data  <= m.rdata;
            r_out_addr  <= r_raddr;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_rem == ONE);
            r_raddr     <= r_raddr + 1'b1;
            r_rem       <= r_rem - ONE;
            if (r_rem == ONE) begin
              r_lock  <= 1'b0;
              r_state <= DRAIN;
            end
          end else if (w_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign m.raddr     = r_raddr;
  assign m.rf_lock   = r_lock;
  assign m.out_valid = r_out_valid;
  assign m.out_data  = r_out_data;
  assign m.out_addr  = r_out_addr;
  assign m.out_last  = r_out_last;
  assign m.busy      = r_busy;
  assign m.done      = r_done;
endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: randomized and directed checks of regfile_reader against a block-level model
module tb_regfile_reader;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  regfile_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_reader #(.DATA_W(DW), .ADDR_W(AW), .NREG(N)) dut (.clk(clk), .rst(rst), .m(bus));
  logic [DW-1:0] regs [N];
  assign bus.rdata = bus.rf_we ? '0 : regs[bus.raddr];
  int n_cmp = 0;
  int n_bad = 0;
  int oa[$]; logic [DW-1:0] od[$]; bit ol[$]; int oc[$]; bit bq[$]; bit lq[$];
  int ea[$]; logic [DW-1:0] ed[$]; bit el[$];
  int done_cyc, done_extra, stab_err;
  bit rdy_pat[$]; bit we_pat[$];
  bit rnd = 0;
  int inj_cyc = -1;
  logic [AW-1:0] inj_b;
  logic [AW:0] inj_c;

  // expected stream: min(count,N) consecutive addresses from base, modulo N
  function automatic void model(input int b, input int c);
    int n;
    ea.delete(); ed.delete(); el.delete();
    n = (c > N) ? N : c;
    for (int j = 0; j < n; j++) begin
      ea.push_back((b + j) % N);
      ed.push_back(regs[(b + j) % N]);
      el.push_back(j == n - 1);
    end
  endfunction

  task automatic run_block(input logic [AW-1:0] b, input logic [AW:0] c);
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    oa.delete(); od.delete(); ol.delete(); oc.delete(); bq.delete(); lq.delete();
    done_cyc = -1; done_extra = 0; stab_err = 0;
    pv = 0; pr = 0; pl = 0; pd = '0; pa = '0;
    bus.start = 1'b1; bus.base = b; bus.count = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin bus.base = inj_b; bus.count = inj_c; end
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : (rdy_pat.size() != 0 ? rdy_pat.pop_front() : 1'b1);
      bus.rf_we     = rnd ? ($urandom_range(0, 3) == 0) : (we_pat.size() != 0 ? we_pat.pop_front() : 1'b0);
      @(negedge clk);
      bq.push_back(bus.busy); lq.push_back(bus.rf_lock);
      if (pv && !pr && (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_addr !== pa || bus.out_last !== pl)) stab_err++;
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pa = bus.out_addr; pl = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        oa.push_back(int'(bus.out_addr)); od.push_back(bus.out_data); ol.push_back(bus.out_last); oc.push_back(cyc);
      end
      if (bus.done) begin done_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.out_ready = 1'b1; bus.rf_we = 1'b0;
    @(negedge clk);
    done_extra = bus.done;
    @(posedge clk); #1;
    inj_cyc = -1; rnd = 0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.base = '0; bus.count = '0; bus.out_ready = 1; bus.rf_we = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.raddr, bus.out_data, bus.out_addr, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.rf_lock} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got raddr=%0d data=%h addr=%0d v=%b l=%b busy=%b done=%b lock=%b want all 0",
        bus.raddr, bus.out_data, bus.out_addr, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.rf_lock);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.busy, bus.done, bus.rf_lock} !== 4'b0) begin
      n_bad++; $display("FAIL reset_idle got v/busy/done/lock=%b want 0000", {bus.out_valid, bus.busy, bus.done, bus.rf_lock});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) regs[i] = 32'h100 + i;
    model(4, 3);
    run_block(4, 3);
    n_cmp++;
    if (oa.size() != ea.size()) begin n_bad++; $display("FAIL basic_len got %0d want %0d", oa.size(), ea.size()); end
    for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
      n_cmp++;
      if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j] || oc[j] !== j + 1) begin
        n_bad++; $display("FAIL basic_word%0d got a=%0d d=%h l=%b cyc=%0d want a=%0d d=%h l=%b cyc=%0d", j, oa[j], od[j], ol[j], oc[j], ea[j], ed[j], el[j], j + 1);
      end
    end
    for (int j = 0; j < 5 && j < bq.size(); j++) begin
      n_cmp++;
      if (bq[j] !== (j < 4) || lq[j] !== (j < 3)) begin
        n_bad++; $display("FAIL basic_busy_lock cyc%0d got busy=%b lock=%b want busy=%b lock=%b", j, bq[j], lq[j], j < 4, j < 3);
      end
    end
    n_cmp++;
    if (done_cyc != 4 || done_extra != 0) begin n_bad++; $display("FAIL basic_done got cyc=%0d extra=%0d want cyc=4 extra=0", done_cyc, done_extra); end
  endtask

  task automatic test_wrap_clamp();
    model(30, 4);
    run_block(30, 4);
    n_cmp++;
    if (oa.size() != ea.size() || done_cyc != 5) begin n_bad++; $display("FAIL wrap_len got n=%0d done=%0d want n=%0d done=5", oa.size(), done_cyc, ea.size()); end
    for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
      n_cmp++;
      if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j]) begin
        n_bad++; $display("FAIL wrap_word%0d got a=%0d d=%h l=%b want a=%0d d=%h l=%b", j, oa[j], od[j], ol[j], ea[j], ed[j], el[j]);
      end
    end
    model(7, 40);
    run_block(7, 40);
    n_cmp++;
    if (oa.size() != 32 || done_cyc != 33) begin n_bad++; $display("FAIL clamp_len got n=%0d done=%0d want n=32 done=33", oa.size(), done_cyc); end
    for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
      n_cmp++;
      if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j]) begin
        n_bad++; $display("FAIL clamp_word%0d got a=%0d d=%h l=%b want a=%0d d=%h l=%b", j, oa[j], od[j], ol[j], ea[j], ed[j], el[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    rdy_pat = '{1, 1, 0, 0, 0};
    model(12, 4);
    run_block(12, 4);
    n_cmp++;
    if (oa.size() != ea.size() || done_cyc != 8 || stab_err != 0) begin
      n_bad++; $display("FAIL bp_summary got n=%0d done=%0d stab=%0d want n=%0d done=8 stab=0", oa.size(), done_cyc, stab_err, ea.size());
    end
    for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
      n_cmp++;
      if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j] || oc[j] !== ((j == 0) ? 1 : j + 4)) begin
        n_bad++; $display("FAIL bp_word%0d got a=%0d d=%h l=%b cyc=%0d want a=%0d d=%h l=%b cyc=%0d", j, oa[j], od[j], ol[j], oc[j], ea[j], ed[j], el[j], (j == 0) ? 1 : j + 4);
      end
    end
  endtask

  task automatic test_collision();
    we_pat = '{0, 1, 1};
    model(20, 3);
    run_block(20, 3);
    n_cmp++;
    if (oa.size() != ea.size() || done_cyc != 6) begin n_bad++; $display("FAIL coll_len got n=%0d done=%0d want n=%0d done=6", oa.size(), done_cyc, ea.size()); end
    for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
      n_cmp++;
      if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j] || oc[j] !== ((j == 0) ? 1 : j + 3)) begin
        n_bad++; $display("FAIL coll_word%0d got a=%0d d=%h l=%b cyc=%0d want a=%0d d=%h l=%b cyc=%0d", j, oa[j], od[j], ol[j], oc[j], ea[j], ed[j], el[j], (j == 0) ? 1 : j + 3);
      end
    end
  endtask

  task automatic test_edge();
    run_block(3, 0);
    n_cmp++;
    if (oa.size() != 0 || done_cyc != 0 || done_extra != 0 || bq[0] !== 1'b0) begin
      n_bad++; $display("FAIL count0 got n=%0d done=%0d extra=%0d busy=%b want n=0 done=0 extra=0 busy=0", oa.size(), done_cyc, done_extra, bq[0]);
    end
    inj_cyc = 2; inj_b = 5'd20; inj_c = 6'd5;
    model(10, 4);
    run_block(10, 4);
    n_cmp++;
    if (oa.size() != ea.size() || done_cyc != 5 || done_extra != 0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_start got n=%0d done=%0d extra=%0d busy=%b want n=%0d done=5 extra=0 busy=0", oa.size(), done_cyc, done_extra, bus.busy, ea.size());
    end
    for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
      n_cmp++;
      if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j]) begin
        n_bad++; $display("FAIL busy_start_word%0d got a=%0d d=%h want a=%0d d=%h", j, oa[j], od[j], ea[j], ed[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.out_ready = 1; bus.rf_we = 0;
    bus.start = 1; bus.base = 5'd2; bus.count = 6'd8;
    @(posedge clk); #1;
    bus.start = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !(bus.out_valid && bus.out_addr == 5'd4); i++) @(negedge clk);
    n_cmp++;
    if (!(bus.out_valid && bus.out_addr == 5'd4)) begin n_bad++; $display("FAIL rstmid_third got v=%b a=%0d want v=1 a=4", bus.out_valid, bus.out_addr); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.raddr, bus.out_data, bus.out_addr, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.rf_lock} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs got raddr=%0d data=%h v=%b busy=%b lock=%b want all 0", bus.raddr, bus.out_data, bus.out_valid, bus.busy, bus.rf_lock);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); seen |= bus.done; end
    rst = 1'b1;
    repeat (2) begin @(negedge clk); seen |= bus.done | bus.out_valid; end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rstmid_nodone got activity=1 want 0"); end
    @(posedge clk); #1;
    model(9, 3);
    run_block(9, 3);
    n_cmp++;
    if (oa.size() != ea.size() || done_cyc != 4) begin n_bad++; $display("FAIL rstmid_fresh got n=%0d done=%0d want n=%0d done=4", oa.size(), done_cyc, ea.size()); end
    for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
      n_cmp++;
      if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j]) begin
        n_bad++; $display("FAIL rstmid_word%0d got a=%0d d=%h want a=%0d d=%h", j, oa[j], od[j], ea[j], ed[j]);
      end
    end
  endtask

  task automatic test_random();
    int b, c;
    for (int i = 0; i < N; i++) regs[i] = $urandom | 32'h1;
    for (int t = 0; t < 10; t++) begin
      b = $urandom_range(0, N - 1);
      c = $urandom_range(0, 40);
      model(b, c);
      rnd = 1;
      run_block(AW'(b), (AW+1)'(c));
      n_cmp++;
      if (oa.size() != ea.size() || done_cyc < 0 || done_extra != 0 || stab_err != 0) begin
        n_bad++; $display("FAIL rand%0d b=%0d c=%0d got n=%0d done=%0d extra=%0d stab=%0d want n=%0d", t, b, c, oa.size(), done_cyc, done_extra, stab_err, ea.size());
      end
      for (int j = 0; j < ea.size() && j < oa.size(); j++) begin
        n_cmp++;
        if (oa[j] !== ea[j] || od[j] !== ed[j] || ol[j] !== el[j]) begin
          n_bad++; $display("FAIL rand%0d_word%0d got a=%0d d=%h l=%b want a=%0d d=%h l=%b", t, j, oa[j], od[j], ol[j], ea[j], ed[j], el[j]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = '0;
    test_reset();
    test_basic();
    test_wrap_clamp();
    test_backpressure();
    test_collision();
    test_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
